// File: rtl/oneway_reader.sv
// oneway_reader: captures writer bytes on sync rising edges into a FIFO, re-presents them as a valid/ready stream.
// Optional ONEWAY_READER_GAP_CHECK_EN adds gap/gap_valid reporting successive accepted-byte deltas.
module oneway_reader #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    d_in,
  input  logic          sync_in,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic          clr_stat,
  output logic [15:0]   rx_cnt,
  output logic [7:0]    drop_cnt,
  output logic          overflow,
`ifdef ONEWAY_READER_GAP_CHECK_EN
  output logic [7:0]    gap,
  output logic          gap_valid,
`endif
  output logic [AW:0]   level
);
  typedef enum logic {ARMED, HELD} state_t;
  state_t state, state_nx;
  logic capture, full, pop, push, drop;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_comb begin
    state_nx = sync_in ? HELD : ARMED;
    capture = (state == ARMED) & sync_in;
    full = level == (AW+1)'(DEPTH);
    m_valid = level != '0;
    m_data = m_valid ? mem[rd_ptr] : '0;
    pop = m_valid & m_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    push = capture & (~full | pop);
    drop = capture & full & ~pop;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ARMED;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= d_in;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (clr_stat) begin
      rx_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) rx_cnt <= rx_cnt + 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      if (drop) overflow <= 1'b1;
    end
`ifdef ONEWAY_READER_GAP_CHECK_EN
  logic [7:0] ref_byte;
  logic ref_valid;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ref_byte <= '0;
      ref_valid <= 1'b0;
      gap <= '0;
      gap_valid <= 1'b0;
    end else if (clr_stat) begin
      ref_valid <= push;
      gap_valid <= 1'b0;
      if (push) ref_byte <= d_in;
    end else begin
      gap_valid <= push & ref_valid;
      if (push) begin
        gap <= d_in - ref_byte;
        ref_byte <= d_in;
        ref_valid <= 1'b1;
      end
    end
`endif
endmodule

// File: doc/oneway_reader.md
Name: oneway_reader

Overview:
- Downstream consumer of the oneway handshake writer. It samples the writer's 8-bit data bus on each one-cycle sync pulse and buffers the byte in a small FIFO.
- Bytes are re-presented on a valid/ready stream for the next stage.
- Keeps receive and drop statistics so the bench and later stages can confirm that no sync events were lost.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- d_in  input  8  writer data bus; meaningful only while sync_in=1.
- sync_in  input  1  writer sync strobe; same clock domain as clk.
- m_data  output  8  head-of-FIFO byte.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  downstream accepts m_data this cycle.
- clr_stat  input  1  synchronous clear of the statistics.
- rx_cnt  output  16  bytes accepted into the FIFO; wraps modulo 2^16.
- drop_cnt  output  8  bytes dropped because the FIFO was full; saturates at 255.
- overflow  output  1  sticky flag, set on any drop.
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - pointers, level, rx_cnt, drop_cnt and overflow all 0;
  - m_valid=0, m_data=0;
  - sync edge register 0.
  - Reset asserted mid-transfer discards all buffered bytes immediately.
- Capture event:
  - A capture occurs when sync_in=1 and the registered sync_in from the previous cycle is 0 (rising edge).
  - d_in is sampled in that same cycle.
  - If sync_in stays high for N>1 cycles, only the first cycle captures; the event is re-armed only after sync_in returns to 0.
- Capture FSM:
  - ARMED: sync_in=1 -> capture, go to HELD.
  - HELD: sync_in=0 -> ARMED; sync_in=1 -> stay in HELD, no capture.
- Push:
  - On capture with level<DEPTH: write to mem[wr_ptr], wr_ptr+1 (wraps at DEPTH), rx_cnt+1.
  - First byte into an empty FIFO is visible on m_data with m_valid=1 on the cycle after the capture edge. Capture-to-valid latency is 1 clock.
- Pop:
  - Occurs when m_valid & m_ready: rd_ptr+1 (wraps).
  - m_data always shows mem[rd_ptr]; m_data is 0 when empty.
  - m_data must hold stable while m_valid=1 and m_ready=0.
- Simultaneous push and pop:
  - Not full: both happen and level is unchanged.
  - Full: the pop frees a slot in the same cycle, so the push is accepted and no drop occurs.
- Overflow:
  - Occurs on capture with level==DEPTH and no pop that cycle: the byte is discarded.
  - drop_cnt+1, saturating at 255; overflow=1.
  - rx_cnt is unchanged.
- Empty: m_ready while m_valid=0 has no effect.
- clr_stat:
  - Next edge: rx_cnt=0, drop_cnt=0, overflow=0. FIFO contents and pointers are untouched.
  - If a capture coincides with clr_stat, clear wins: counters read 0, but the byte is still pushed if there is space.
- level: counts 0..DEPTH using the extra MSB; full is level==DEPTH, empty is level==0.

Optional Feature:
- Macro: ONEWAY_READER_GAP_CHECK_EN.
- With the macro defined:
  - Adds output gap [7:0] and output gap_valid [1].
  - On each accepted capture after the first since reset or clr_stat, gap = (d_in - previous accepted byte) mod 256, registered, with gap_valid pulsing 1 for one cycle.
  - The first capture only loads the reference byte.
  - Dropped bytes do not update the reference.
- Without the macro: no gap or gap_valid ports and no extra registers.

Test Plan:
- Reset mid-stream: 3 bytes buffered, assert reset=0 -> level=0, m_valid=0, rx_cnt=0, drop_cnt=0 immediately, without waiting for a clock edge.
- Single transfer: sync_in=1 for 1 cycle with d_in=8'h2A, m_ready=1 -> m_valid=1 and m_data=8'h2A on the next cycle only, rx_cnt=1.
- Held sync: sync_in=1 for 4 cycles with d_in=8'h10..8'h13 -> exactly one byte, 8'h10, buffered; rx_cnt=1.
- Overflow: m_ready=0, 6 sync pulses with values 1..6, DEPTH=4 -> FIFO holds 1,2,3,4; drop_cnt=2; overflow=1. Then drain -> outputs 1,2,3,4 in order, level=0.
- Full plus simultaneous pop: FIFO full, capture 8'h99 in the same cycle as m_ready=1 -> no drop, level stays 4, 8'h99 is last out.
- clr_stat plus gap (feature on): after 5 bytes clr_stat=1 -> counters 0. Then captures 8'h20 then 8'h27 -> gap=7 with one gap_valid pulse, and no pulse on 8'h20.
